// File: rtl/irq_pkg.sv
// Shared constants and FSM state encoding for the vectored interrupt controller.
package irq_pkg;

  localparam int unsigned NSRC = 8;
  localparam int unsigned SELW = 3;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StReq     = 2'b01,
    StService = 2'b10
  } irq_state_e;

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder; the lowest set index wins.
module prio_enc8 (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       valid
);

  always_comb begin
    idx   = 3'd0;
    valid = |req;
    // Scan high to low so the last (lowest) set bit is the one kept.
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_vector_ctrl.sv
// Edge-latched, maskable, fixed-priority interrupt controller with a single
// in-service slot and a request/ack handshake to the CPU control unit.
module irq_vector_ctrl
  import irq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] irq_in,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic            cpu_int_en,
  input  logic            irq_ack,
  input  logic            eret,
  output logic            irq_req,
  output logic [SELW-1:0] vec_sel,
  output logic            in_service,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask_q
);

  irq_state_e      state_q;
  logic [NSRC-1:0] irq_prev_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] ack_clr;
  logic [NSRC-1:0] eligible;
  logic [SELW-1:0] winner;
  logic            winner_valid;
  logic            withdraw;

  assign pending  = pending_q;
  assign eligible = pending_q & mask_q;
  assign withdraw = !cpu_int_en || !mask_q[vec_sel];

  prio_enc8 u_prio_enc8 (
    .req   (eligible),
    .idx   (winner),
    .valid (winner_valid)
  );

  always_comb begin
    rise    = irq_in & ~irq_prev_q;
    ack_clr = '0;
    if (state_q == StReq && irq_ack) begin
      ack_clr[vec_sel] = 1'b1;
    end
    // A new edge on the acknowledged source survives the clear.
    pending_d = (pending_q & ~ack_clr) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
    end else begin
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      irq_req    <= 1'b0;
      vec_sel    <= '0;
      in_service <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cpu_int_en && winner_valid) begin
            state_q <= StReq;
            irq_req <= 1'b1;
            vec_sel <= winner;
          end
        end
        StReq: begin
          if (irq_ack) begin
            state_q    <= StService;
            irq_req    <= 1'b0;
            in_service <= 1'b1;
          end else if (withdraw) begin
            state_q <= StIdle;
            irq_req <= 1'b0;
          end
        end
        StService: begin
          if (eret) begin
            state_q    <= StIdle;
            in_service <= 1'b0;
          end
        end
        default: begin
          state_q    <= StIdle;
          irq_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Directed bench for irq_vector_ctrl; expected vectors are queued when sources
// are stimulated and popped when the controller raises a request.
module tb_irq_vector_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       cpu_int_en;
  logic       irq_ack;
  logic       eret;
  logic       irq_req;
  logic [2:0] vec_sel;
  logic       in_service;
  logic [7:0] pending;
  logic [7:0] mask_q;

  int unsigned checks;
  int unsigned failures;
  int unsigned exp_q[$];

  irq_vector_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .cpu_int_en (cpu_int_en),
    .irq_ack    (irq_ack),
    .eret       (eret),
    .irq_req    (irq_req),
    .vec_sel    (vec_sel),
    .in_service (in_service),
    .pending    (pending),
    .mask_q     (mask_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for irq_req, then compare vec_sel against the scoreboard.
  task automatic wait_req(input string tag);
    int unsigned exp_v;
    int          cyc;
    cyc = 0;
    while (irq_req !== 1'b1 && cyc < 10) begin
      tick(1);
      cyc++;
    end
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s: got request with empty scoreboard expected queued vector", tag);
    end else begin
      exp_v = exp_q.pop_front();
      if (irq_req !== 1'b1) begin
        checks++;
        failures++;
        $error("FAIL %s: got no irq_req within 10 cycles expected vec_sel %0d", tag, exp_v);
      end else begin
        chk(tag, 32'(vec_sel), 32'(exp_v));
      end
    end
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick(1);
    eret = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] lines);
    irq_in = lines;
    tick(1);
    irq_in = 8'h00;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    irq_in     = 8'h00;
    mask_we    = 1'b0;
    mask_wdata = 8'h00;
    cpu_int_en = 1'b0;
    irq_ack    = 1'b0;
    eret       = 1'b0;

    #3;
    chk("rst_irq_req", 32'(irq_req), 32'h0);
    chk("rst_vec_sel", 32'(vec_sel), 32'h0);
    chk("rst_in_service", 32'(in_service), 32'h0);
    chk("rst_pending", 32'(pending), 32'h00);
    chk("rst_mask", 32'(mask_q), 32'h00);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    mask_we    = 1'b1;
    mask_wdata = 8'hFF;
    cpu_int_en = 1'b1;
    tick(1);
    mask_we = 1'b0;
    chk("mask_write", 32'(mask_q), 32'hFF);

    // Single source, exact latency.
    pulse(8'h20);
    chk("t1_pending", 32'(pending), 32'h20);
    chk("t1_req_not_yet", 32'(irq_req), 32'h0);
    tick(1);
    chk("t1_req", 32'(irq_req), 32'h1);
    chk("t1_vec", 32'(vec_sel), 32'd5);
    do_ack();
    chk("t1_ack_pending", 32'(pending), 32'h00);
    chk("t1_ack_insvc", 32'(in_service), 32'h1);
    chk("t1_ack_req", 32'(irq_req), 32'h0);
    do_eret();
    chk("t1_eret_insvc", 32'(in_service), 32'h0);
    chk("t1_eret_req", 32'(irq_req), 32'h0);

    // Simultaneous sources: lower index first.
    pulse(8'h44);
    exp_q.push_back(2);
    exp_q.push_back(6);
    wait_req("t2_first");
    do_ack();
    chk("t2_pending_after_ack", 32'(pending), 32'h40);
    do_eret();
    chk("t2_idle_after_eret", 32'(irq_req), 32'h0);
    tick(1);
    chk("t2_req_after_eret", 32'(irq_req), 32'h1);
    wait_req("t2_second");
    do_ack();
    do_eret();

    // vec_sel frozen while a higher-priority source arrives.
    pulse(8'h10);
    exp_q.push_back(4);
    wait_req("t3_first");
    pulse(8'h02);
    tick(2);
    chk("t3_frozen_vec", 32'(vec_sel), 32'd4);
    chk("t3_frozen_req", 32'(irq_req), 32'h1);
    do_ack();
    chk("t3_pending", 32'(pending), 32'h02);
    do_eret();
    exp_q.push_back(1);
    wait_req("t3_second");
    do_ack();
    do_eret();

    // Withdrawal by masking the requesting source.
    pulse(8'h08);
    exp_q.push_back(3);
    wait_req("t4_first");
    mask_we    = 1'b1;
    mask_wdata = 8'hF7;
    tick(1);
    mask_we = 1'b0;
    chk("t4_req_still", 32'(irq_req), 32'h1);
    tick(1);
    chk("t4_req_dropped", 32'(irq_req), 32'h0);
    chk("t4_pending_kept", 32'(pending), 32'h08);
    tick(2);
    chk("t4_stays_idle", 32'(irq_req), 32'h0);
    mask_we    = 1'b1;
    mask_wdata = 8'hFF;
    tick(1);
    mask_we = 1'b0;
    exp_q.push_back(3);
    wait_req("t4_reassert");
    do_ack();
    do_eret();

    // Global enable gating, then ack racing a new edge on the same source.
    cpu_int_en = 1'b0;
    pulse(8'h81);
    tick(3);
    chk("t5_pending", 32'(pending), 32'h81);
    chk("t5_gated", 32'(irq_req), 32'h0);
    cpu_int_en = 1'b1;
    exp_q.push_back(0);
    wait_req("t5_vec");
    irq_in  = 8'h01;
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    chk("t5_set_wins", 32'(pending), 32'h81);
    chk("t5_insvc", 32'(in_service), 32'h1);
    // Held level must not re-pend after the bit is cleared elsewhere.
    tick(2);
    chk("t5_no_retrigger_req", 32'(irq_req), 32'h0);

    // Asynchronous reset during SERVICE.
    rst_n = 1'b0;
    #2;
    chk("t6_req", 32'(irq_req), 32'h0);
    chk("t6_insvc", 32'(in_service), 32'h0);
    chk("t6_pending", 32'(pending), 32'h00);
    chk("t6_mask", 32'(mask_q), 32'h00);
    chk("t6_vec", 32'(vec_sel), 32'h0);
    irq_in = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("t6_after_release", 32'(pending), 32'h00);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
